// File: rtl/nonce_dispatcher_if.sv
// Message/result handshake bundle between the nonce dispatcher and one SHA-1 search tile.
//   msg_val/msg/msg_rdy    : dispatcher -> tile message stream (val/rdy)
//   dgst_val/dgst/dgst_rdy : tile -> dispatcher in-order match bits (val/rdy)
// master = dispatcher side, slave = tile side.
interface nonce_dispatcher_if #(
  parameter int MSG_LEN = 1234
);
  logic               msg_val;
  logic [MSG_LEN-1:0] msg;
  logic               msg_rdy;
  logic               dgst_val;
  logic               dgst;
  logic               dgst_rdy;

  modport master (output msg_val, output msg, input msg_rdy,
                  input dgst_val, input dgst, output dgst_rdy);
  modport slave  (input msg_val, input msg, output msg_rdy,
                  output dgst_val, output dgst, input dgst_rdy);
endinterface

// File: rtl/nonce_dispatcher.sv
// Sweeps a nonce range [lo, hi] and feeds one search tile with base message + nonce.
// Tracks issued nonces in a FIFO so the tile's in-order match bits can be mapped back
// to nonces. Reports the first matching nonce or range exhaustion.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   start_i, base_i,           sweep start (IDLE/DONE only) with captured base message
//   nonce_lo_i, nonce_hi_i     and inclusive nonce range
//   tile (master)              msg/dgst handshakes to the tile
//   busy_o, done_o             RUN/DRAIN, DONE status
//   found_o, found_nonce_o     first match result (valid with done_o)
//   err_o                      sticky: result offered with nothing outstanding
module nonce_dispatcher #(
  parameter int MSG_LEN   = 1234,
  parameter int NONCE_W   = 32,
  parameter int NONCE_LSB = 0,
  parameter int DEPTH     = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [MSG_LEN-1:0]  base_i,
  input  logic [NONCE_W-1:0]  nonce_lo_i,
  input  logic [NONCE_W-1:0]  nonce_hi_i,
  nonce_dispatcher_if.master  tile,
  output logic                busy_o,
  output logic                done_o,
  output logic                found_o,
  output logic [NONCE_W-1:0]  found_nonce_o,
  output logic                err_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [MSG_LEN-1:0] base_q;
  logic [NONCE_W-1:0] cur_q, hi_q, found_nonce_q;
  logic               found_q, err_q;

  logic [NONCE_W-1:0] fifo_q [DEPTH];
  logic [AW-1:0]      wp_q, rp_q;
  logic [AW:0]        cnt_q, cnt_d;

  logic msg_val_w, dgst_rdy_w, push, pop, match, last, start_ok;

  assign push     = msg_val_w && tile.msg_rdy;
  assign pop      = dgst_rdy_w && tile.dgst_val;
  assign match    = pop && tile.dgst && !found_q;
  assign last     = (cur_q == hi_q);
  assign start_ok = start_i && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) state_d = (nonce_lo_i > nonce_hi_i) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        // Issuing stops on the last nonce or the first match; skip DRAIN
        // when nothing is left outstanding so done follows the last result directly.
        if (match || (push && last)) state_d = (cnt_d == '0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_d == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    // cnt_q <= DEPTH and DEPTH is a power of 2, so the MSB alone flags "full".
    msg_val_w     = (state_q == S_RUN) && !cnt_q[AW];
    dgst_rdy_w    = (state_q == S_RUN || state_q == S_DRAIN) && (cnt_q != '0);
    tile.msg_val  = msg_val_w;
    tile.dgst_rdy = dgst_rdy_w;
    tile.msg      = base_q;
    tile.msg[NONCE_LSB +: NONCE_W] = cur_q;
    busy_o        = (state_q == S_RUN || state_q == S_DRAIN);
    done_o        = (state_q == S_DONE);
    found_o       = found_q;
    found_nonce_o = found_nonce_q;
    err_o         = err_q;
  end

  // ---------------- nonce tracking FIFO storage ----------------
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wp_q] <= cur_q;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q        <= '0;
      cur_q         <= '0;
      hi_q          <= '0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      err_q         <= 1'b0;
      wp_q          <= '0;
      rp_q          <= '0;
      cnt_q         <= '0;
    end else begin
      if (start_ok) begin
        base_q        <= base_i;
        cur_q         <= nonce_lo_i;
        hi_q          <= nonce_hi_i;
        found_q       <= 1'b0;
        found_nonce_q <= '0;
      end
      if (push) begin
        wp_q <= wp_q + 1'b1;
        // Hold at hi instead of wrapping; the FSM leaves RUN on this push.
        if (!last) cur_q <= cur_q + 1'b1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_d;
      if (match) begin
        found_q       <= 1'b1;
        found_nonce_q <= fifo_q[rp_q];
      end
      if (busy_o && tile.dgst_val && cnt_q == '0) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nonce_dispatcher.sv
module tb_nonce_dispatcher;
  localparam int ML  = 128;
  localparam int NW  = 32;
  localparam int LSB = 16;
  localparam int D   = 4;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [ML-1:0] base;
  logic [NW-1:0] lo_i, hi_i, fn;
  logic          busy, done, found, err;

  nonce_dispatcher_if #(.MSG_LEN(ML)) tif();

  nonce_dispatcher #(.MSG_LEN(ML), .NONCE_W(NW), .NONCE_LSB(LSB), .DEPTH(D)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_i(base),
    .nonce_lo_i(lo_i), .nonce_hi_i(hi_i), .tile(tif.master),
    .busy_o(busy), .done_o(done), .found_o(found), .found_nonce_o(fn), .err_o(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mset[$];   // nonces the modelled tile reports as matches

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chkm(input string tag, input logic [ML-1:0] obs, input logic [ML-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_match(input logic [31:0] n);
    foreach (mset[i]) if (mset[i] == n) return 1'b1;
    return 1'b0;
  endfunction

  task automatic reset_chk(input string tag);
    chk1({tag, " msg_val"}, tif.msg_val, 1'b0);
    chkm({tag, " msg"}, tif.msg, '0);
    chk1({tag, " dgst_rdy"}, tif.dgst_rdy, 1'b0);
    chk1({tag, " busy"}, busy, 1'b0);
    chk1({tag, " done"}, done, 1'b0);
    chk1({tag, " found"}, found, 1'b0);
    chk32({tag, " found_nonce"}, fn, 32'h0);
    chk1({tag, " err"}, err, 1'b0);
  endtask

  // One full sweep against a queue-based model of issued-but-unanswered nonces.
  task automatic sweep(input logic [ML-1:0] b, input logic [31:0] lo, input logic [31:0] hi,
                       input int hold, input int rp, input int vp,
                       output int issued, output int at_hold, output logic [31:0] first);
    logic [32:0]   nxt;
    logic [31:0]   tq[$];
    logic [ML-1:0] em, pm;
    logic          stop, ffound, ex_done, ended, pv;
    @(negedge clk);
    start = 1'b1; base = b; lo_i = lo; hi_i = hi;
    tif.msg_rdy = 1'b0; tif.dgst_val = 1'b0; tif.dgst = 1'b0;
    @(negedge clk);
    start = 1'b0; base = ~b; lo_i = $urandom; hi_i = $urandom;  // must already be captured
    nxt = {1'b0, lo}; stop = (lo > hi); issued = 0; at_hold = -1;
    ffound = 1'b0; first = '0; ended = 1'b0; pv = 1'b0; pm = '0;
    for (int c = 0; c < 3000 && !ended; c++) begin
      if (c > 0) @(negedge clk);
      tif.msg_rdy  = ($urandom_range(0, 99) < rp);
      tif.dgst_val = (tq.size() > 0) && (c >= hold) && ($urandom_range(0, 99) < vp);
      tif.dgst     = (tq.size() > 0) ? is_match(tq[0]) : 1'b0;
      #1;
      if (c == hold) at_hold = issued;
      ex_done = stop && (tq.size() == 0);
      chk1("done_o", done, ex_done);
      if (done || ex_done) begin
        ended = 1'b1;
      end else begin
        chk1("busy_o", busy, 1'b1);
        chk1("msg_val_o", tif.msg_val, !stop && (tq.size() < D));
        chk1("dgst_rdy_o", tif.dgst_rdy, tq.size() > 0);
        if (pv) chkm("msg_o held", tif.msg, pm);
        pv = tif.msg_val && !tif.msg_rdy;
        pm = tif.msg;
        if (tif.msg_val && tif.msg_rdy) begin
          em = b;
          em[LSB +: NW] = nxt[31:0];
          chkm("msg_o", tif.msg, em);
          tq.push_back(nxt[31:0]);
          issued++;
          if (nxt[31:0] == hi) stop = 1'b1;
          nxt = nxt + 33'd1;
        end
        if (tif.dgst_val && tif.dgst_rdy) begin
          if (tif.dgst && !ffound) begin
            ffound = 1'b1; first = tq[0]; stop = 1'b1;
          end
          void'(tq.pop_front());
        end
      end
    end
    chk1("sweep ended", ended, 1'b1);
    tif.msg_rdy = 1'b0; tif.dgst_val = 1'b0; tif.dgst = 1'b0;
    chk1("found_o", found, ffound);
    if (ffound) chk32("found_nonce_o", fn, first);
    chk1("done busy_o", busy, 1'b0);
    chk1("done msg_val_o", tif.msg_val, 1'b0);
    chk1("done dgst_rdy_o", tif.dgst_rdy, 1'b0);
    chk1("err_o quiet", err, 1'b0);
  endtask

  initial begin
    int iss, ah;
    logic [31:0] fst, lo, len;
    logic [ML-1:0] b;
    rst = 1'b1; start = 1'b0; base = '0; lo_i = '0; hi_i = '0;
    tif.msg_rdy = 1'b0; tif.dgst_val = 1'b0; tif.dgst = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_chk("reset");
    @(negedge clk) rst = 1'b0;

    // nonces 5..8, tile answers 0,0,1,0
    b = {$urandom, $urandom, $urandom, $urandom};
    mset.delete(); mset.push_back(32'd7);
    sweep(b, 32'd5, 32'd8, 0, 100, 100, iss, ah, fst);
    chk32("t1 issued", 32'(iss), 32'd4);
    chk32("t1 found_nonce", fn, 32'd7);
    chk1("t1 found", found, 1'b1);

    // single all-ones nonce, no wrap
    mset.delete();
    sweep(~b, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 100, 100, iss, ah, fst);
    chk32("t2 issued", 32'(iss), 32'd1);
    chk1("t2 found", found, 1'b0);

    // empty range
    sweep(b, 32'd10, 32'd3, 0, 100, 100, iss, ah, fst);
    chk32("t3 issued", 32'(iss), 32'd0);
    chk1("t3 found", found, 1'b0);

    // results held off: DEPTH messages then stall
    sweep(b, 32'd100, 32'd200, 20, 100, 100, iss, ah, fst);
    chk32("t4 issued at holdoff", 32'(ah), 32'(D));
    chk32("t4 issued", 32'(iss), 32'd101);

    // two matches while several are outstanding: first wins
    mset.delete(); mset.push_back(32'd2); mset.push_back(32'd3);
    sweep(b, 32'd0, 32'd20, 3, 100, 100, iss, ah, fst);
    chk32("t5 found_nonce", fn, 32'd2);

    // randomized sweeps
    for (int s = 0; s < 10; s++) begin
      b   = {$urandom, $urandom, $urandom, $urandom};
      lo  = (s % 3 == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 5))) : $urandom;
      len = 32'($urandom_range(0, 12));
      mset.delete();
      if ($urandom_range(0, 2) != 0) mset.push_back(lo + 32'($urandom_range(0, 12)));
      if ($urandom_range(0, 1) != 0) mset.push_back(lo + 32'($urandom_range(0, 12)));
      sweep(b, lo, lo + len, $urandom_range(0, 6), $urandom_range(30, 100),
            $urandom_range(30, 100), iss, ah, fst);
    end

    // unsolicited result in RUN, then reset mid-sweep
    @(negedge clk);
    start = 1'b1; base = b; lo_i = 32'd0; hi_i = 32'd100; tif.msg_rdy = 1'b0;
    @(negedge clk);
    start = 1'b0; tif.dgst_val = 1'b1; tif.dgst = 1'b1;
    #1;
    chk1("t6 dgst_rdy", tif.dgst_rdy, 1'b0);
    chk1("t6 msg_val", tif.msg_val, 1'b1);
    chk1("t6 err before", err, 1'b0);
    @(negedge clk);
    tif.dgst_val = 1'b0; tif.dgst = 1'b0;
    #1 chk1("t6 err set", err, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk1("t6 err sticky", err, 1'b1);
    chk1("t6 busy", busy, 1'b1);
    chk1("t6 found", found, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 reset_chk("t6 reset");
    @(negedge clk) rst = 1'b0;
    #1 reset_chk("t6 after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
